fb_write_sched: RTL and testbench

Write-side scheduler for the dual-write-port frame buffer RAM. It shares the RAM's write path between two pixel requesters (for example the drawing engine and the sprite/overlay engine) with round-robin arbitration. It also provides a built-in full-screen clear sweep. It drives exactly one registered write per `clk_w` cycle into the frame buffer's primary write port (`addr_in`/`data_in`/`regwrite`), which leaves the RAM's internal port multiplexing uncontended.

---
 rtl/fb_pkg.sv | 15 +
 rtl/fb_write_sched_if.sv | 49 ++++
 rtl/fb_write_sched_rr_arb2.sv | 23 ++
 rtl/fb_write_sched.sv | 124 ++++++++++++
 tb/tb_fb_write_sched.sv | 314 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fb_pkg.sv
// fb_write_sched shared types and constants.
// State encoding, default geometry and fill value.
package fb_pkg;

  localparam int FB_AW = 15;
  localparam int FB_DW = 3;

  localparam logic [FB_DW-1:0] FB_BLACK = '0;

  typedef enum logic {
    FB_IDLE  = 1'b0,
    FB_CLEAR = 1'b1
  } fb_state_e;

endpackage

// File: rtl/fb_write_sched_if.sv
// Requester, clear and RAM write bundle.
// slave = scheduler side, master = client side.
interface fb_write_sched_if
  import fb_pkg::*;
#(
  parameter int AW = FB_AW,
  parameter int DW = FB_DW
);

  logic          req0_valid;
  logic [AW-1:0] req0_addr;
  logic [DW-1:0] req0_data;
  logic          req0_ready;

  logic          req1_valid;
  logic [AW-1:0] req1_addr;
  logic [DW-1:0] req1_data;
  logic          req1_ready;

  logic          clr_start;
  logic [DW-1:0] clr_color;
  logic          clr_busy;
  logic          clr_done;

  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          wr_en;

  modport slave (
    input  req0_valid, req0_addr, req0_data,
    output req0_ready,
    input  req1_valid, req1_addr, req1_data,
    output req1_ready,
    input  clr_start, clr_color,
    output clr_busy, clr_done,
    output wr_addr, wr_data, wr_en
  );

  modport master (
    output req0_valid, req0_addr, req0_data,
    input  req0_ready,
    output req1_valid, req1_addr, req1_data,
    input  req1_ready,
    output clr_start, clr_color,
    input  clr_busy, clr_done,
    input  wr_addr, wr_data, wr_en
  );

endinterface

// File: rtl/fb_write_sched_rr_arb2.sv
// Two-way round-robin grant.
// On a tie the side not granted last time wins.
module rr_arb2 (
  input  logic [1:0] req_i,
  input  logic       en_i,
  input  logic       last_i,
  output logic [1:0] gnt_o
);

  // one-hot grant, at most one bit set
  always_comb begin
    gnt_o = 2'b00;
    if (en_i) begin
      unique case (1'b1)
        (req_i == 2'b11): gnt_o = last_i ? 2'b01 : 2'b10;
        (req_i == 2'b01): gnt_o = 2'b01;
        (req_i == 2'b10): gnt_o = 2'b10;
        default:          gnt_o = 2'b00;
      endcase
    end
  end

endmodule

// File: rtl/fb_write_sched.sv
// Frame buffer write scheduler: two requesters
// plus a full-buffer clear sweep, one write/cycle.
module fb_write_sched
  import fb_pkg::*;
#(
  parameter int AW = FB_AW,
  parameter int DW = FB_DW
) (
  input  logic           clk_w,
  input  logic           reset,
  fb_write_sched_if.slave bus
);

  localparam logic [AW:0] CNT_LAST = {1'b0, {AW{1'b1}}};
  localparam logic [AW:0] CNT_ONE  = {{AW{1'b0}}, 1'b1};

  fb_state_e     state_q, state_d;
  logic          last_q, last_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic [DW-1:0] color_q, color_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] data_q, data_d;
  logic          wen_q, wen_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;

  logic          arb_en;
  logic [1:0]    gnt;

  assign arb_en = (state_q == FB_IDLE)
                & ~bus.clr_start
                & ~reset;

  rr_arb2 u_arb (
    .req_i  ({bus.req1_valid, bus.req0_valid}),
    .en_i   (arb_en),
    .last_i (last_q),
    .gnt_o  (gnt)
  );

  assign bus.req0_ready = gnt[0];
  assign bus.req1_ready = gnt[1];
  assign bus.wr_addr    = addr_q;
  assign bus.wr_data    = data_q;
  assign bus.wr_en      = wen_q;
  assign bus.clr_busy   = busy_q;
  assign bus.clr_done   = done_q;

  // next state, grants and the next registered write
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    color_d = color_q;
    addr_d  = addr_q;
    data_d  = data_q;
    wen_d   = 1'b0;
    done_d  = 1'b0;
    unique case (state_q)
      FB_IDLE: begin
        if (bus.clr_start) begin
          // address 0 leaves with the start so the
          // first write lines up with busy rising;
          // the counter then holds the next address
          color_d = bus.clr_color;
          cnt_d   = CNT_ONE;
          wen_d   = 1'b1;
          addr_d  = '0;
          data_d  = bus.clr_color;
          state_d = FB_CLEAR;
        end else if (gnt[0]) begin
          wen_d  = 1'b1;
          addr_d = bus.req0_addr;
          data_d = bus.req0_data;
          last_d = 1'b0;
        end else if (gnt[1]) begin
          wen_d  = 1'b1;
          addr_d = bus.req1_addr;
          data_d = bus.req1_data;
          last_d = 1'b1;
        end
      end
      FB_CLEAR: begin
        wen_d  = 1'b1;
        addr_d = cnt_q[AW-1:0];
        data_d = color_q;
        if (cnt_q == CNT_LAST) begin
          state_d = FB_IDLE;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: state_d = FB_IDLE;
    endcase
    busy_d = (state_d == FB_CLEAR) | done_d;
  end

  // state, pointer, counter and output registers
  always_ff @(posedge clk_w or posedge reset) begin
    if (reset) begin
      state_q <= FB_IDLE;
      last_q  <= 1'b1;
      cnt_q   <= '0;
      color_q <= DW'(FB_BLACK);
      addr_q  <= '0;
      data_q  <= '0;
      wen_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      color_q <= color_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      wen_q   <= wen_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

endmodule

// File: tb/tb_fb_write_sched.sv
// Directed bench for fb_write_sched.
// Wide instance for requesters, AW=4 for sweeps.
module tb_fb_write_sched;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  fb_write_sched_if #(.AW(15), .DW(3)) bb ();
  fb_write_sched_if #(.AW(4),  .DW(3)) sb ();

  fb_write_sched #(.AW(15), .DW(3)) u_big (
    .clk_w (clk),
    .reset (rst),
    .bus   (bb.slave)
  );

  fb_write_sched #(.AW(4), .DW(3)) u_small (
    .clk_w (clk),
    .reset (rst),
    .bus   (sb.slave)
  );

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs;
    bb.req0_valid = 0; bb.req0_addr = '0; bb.req0_data = '0;
    bb.req1_valid = 0; bb.req1_addr = '0; bb.req1_data = '0;
    bb.clr_start = 0; bb.clr_color = '0;
    sb.req0_valid = 0; sb.req0_addr = '0; sb.req0_data = '0;
    sb.req1_valid = 0; sb.req1_addr = '0; sb.req1_data = '0;
    sb.clr_start = 0; sb.clr_color = '0;
  endtask

  task automatic test_reset;
    logic [22:0] o;
    idle_inputs();
    rst = 1;
    #2;
    o = {bb.wr_en, bb.wr_addr, bb.wr_data, bb.clr_busy, bb.clr_done,
         bb.req0_ready, bb.req1_ready};
    checks++;
    if (o !== '0) begin
      failures++;
      $display("FAIL reset_init got=%h exp=0", o);
    end
    @(negedge clk);
    rst = 0;
    step();
    bb.req0_valid = 1; bb.req0_addr = 15'h0042; bb.req0_data = 3'd2;
    step();
    checks++;
    if ({bb.wr_en, bb.wr_addr} !== {1'b1, 15'h0042}) begin
      failures++;
      $display("FAIL pre_reset_wr got=%b/%h exp=1/0042", bb.wr_en, bb.wr_addr);
    end
    bb.req1_valid = 1; bb.req1_addr = 15'h0077; bb.req1_data = 3'd1;
    rst = 1;
    #1;
    o = {bb.wr_en, bb.wr_addr, bb.wr_data, bb.clr_busy, bb.clr_done,
         bb.req0_ready, bb.req1_ready};
    checks++;
    if (o !== '0) begin
      failures++;
      $display("FAIL reset_async got=%h exp=0", o);
    end
    @(negedge clk);
    rst = 0;
    #1;
    checks++;
    if ({bb.req1_ready, bb.req0_ready} !== 2'b01) begin
      failures++;
      $display("FAIL reset_first_tie got=%b exp=01",
               {bb.req1_ready, bb.req0_ready});
    end
    step();
    bb.req0_valid = 0; bb.req1_valid = 0;
    checks++;
    if ({bb.wr_en, bb.wr_addr} !== {1'b1, 15'h0042}) begin
      failures++;
      $display("FAIL reset_tie_wr got=%b/%h exp=1/0042", bb.wr_en, bb.wr_addr);
    end
  endtask

  task automatic test_single;
    bb.req0_valid = 0;
    bb.req1_valid = 1; bb.req1_addr = 15'h1234; bb.req1_data = 3'd5;
    #1;
    checks++;
    if ({bb.req1_ready, bb.req0_ready} !== 2'b10) begin
      failures++;
      $display("FAIL single_ready got=%b exp=10",
               {bb.req1_ready, bb.req0_ready});
    end
    step();
    bb.req1_valid = 0;
    checks++;
    if ({bb.wr_en, bb.wr_addr, bb.wr_data} !== {1'b1, 15'h1234, 3'd5}) begin
      failures++;
      $display("FAIL single_wr got=%b/%h/%0d exp=1/1234/5",
               bb.wr_en, bb.wr_addr, bb.wr_data);
    end
    step();
    checks++;
    if ({bb.wr_en, bb.wr_addr, bb.wr_data} !== {1'b0, 15'h1234, 3'd5}) begin
      failures++;
      $display("FAIL single_hold got=%b/%h/%0d exp=0/1234/5",
               bb.wr_en, bb.wr_addr, bb.wr_data);
    end
  endtask

  task automatic test_contention;
    int n0 = 0;
    int n1 = 0;
    logic [14:0] a0, a1, ea;
    logic [1:0] eg;
    for (int i = 0; i < 6; i++) begin
      a0 = 15'(32'h0100 + n0);
      a1 = 15'(32'h0200 + n1);
      bb.req0_valid = 1; bb.req0_addr = a0; bb.req0_data = 3'(n0);
      bb.req1_valid = 1; bb.req1_addr = a1; bb.req1_data = 3'(n1 + 4);
      #1;
      eg = (i % 2 == 0) ? 2'b01 : 2'b10;
      ea = (i % 2 == 0) ? a0 : a1;
      checks++;
      if ({bb.req1_ready, bb.req0_ready} !== eg) begin
        failures++;
        $display("FAIL contention_gnt%0d got=%b exp=%b", i,
                 {bb.req1_ready, bb.req0_ready}, eg);
      end
      step();
      checks++;
      if ({bb.wr_en, bb.wr_addr} !== {1'b1, ea}) begin
        failures++;
        $display("FAIL contention_wr%0d got=%b/%h exp=1/%h", i,
                 bb.wr_en, bb.wr_addr, ea);
      end
      if (i % 2 == 0) n0++;
      else n1++;
    end
    bb.req0_valid = 0; bb.req1_valid = 0;
    step();
    checks++;
    if (bb.wr_en !== 1'b0) begin
      failures++;
      $display("FAIL contention_idle got=%b exp=0", bb.wr_en);
    end
  endtask

  task automatic test_clear;
    sb.req0_valid = 1; sb.req0_addr = 4'hA; sb.req0_data = 3'd1;
    sb.clr_start = 1; sb.clr_color = 3'd3;
    #1;
    checks++;
    if ({sb.req1_ready, sb.req0_ready} !== 2'b00) begin
      failures++;
      $display("FAIL clear_start_gnt got=%b exp=00",
               {sb.req1_ready, sb.req0_ready});
    end
    step();
    sb.clr_start = 0; sb.clr_color = 3'd0;
    for (int k = 0; k < 16; k++) begin
      checks++;
      if ({sb.wr_en, sb.wr_addr, sb.wr_data, sb.clr_busy}
          !== {1'b1, 4'(k), 3'd3, 1'b1}) begin
        failures++;
        $display("FAIL clear_wr%0d got=%b/%h/%0d/%b exp=1/%h/3/1", k,
                 sb.wr_en, sb.wr_addr, sb.wr_data, sb.clr_busy, 4'(k));
      end
      checks++;
      if (sb.clr_done !== (k == 15)) begin
        failures++;
        $display("FAIL clear_done%0d got=%b exp=%b", k, sb.clr_done, k == 15);
      end
      checks++;
      if ({sb.req1_ready, sb.req0_ready} !== {1'b0, k == 15}) begin
        failures++;
        $display("FAIL clear_ready%0d got=%b exp=0%b", k,
                 {sb.req1_ready, sb.req0_ready}, k == 15);
      end
      step();
    end
    checks++;
    if ({sb.clr_busy, sb.clr_done, sb.wr_en, sb.wr_addr, sb.wr_data}
        !== {1'b0, 1'b0, 1'b1, 4'hA, 3'd1}) begin
      failures++;
      $display("FAIL clear_resume got=%b%b%b/%h/%0d exp=001/a/1",
               sb.clr_busy, sb.clr_done, sb.wr_en, sb.wr_addr, sb.wr_data);
    end
    sb.req0_valid = 0;
    step();
    checks++;
    if (sb.wr_en !== 1'b0) begin
      failures++;
      $display("FAIL clear_after got=%b exp=0", sb.wr_en);
    end
  endtask

  task automatic test_collision;
    int writes = 0;
    int dones = 0;
    int k = 0;
    sb.req0_valid = 1; sb.req0_addr = 4'h2; sb.req0_data = 3'd4;
    sb.req1_valid = 1; sb.req1_addr = 4'h5; sb.req1_data = 3'd6;
    sb.clr_start = 1; sb.clr_color = 3'd7;
    #1;
    checks++;
    if ({sb.req1_ready, sb.req0_ready} !== 2'b00) begin
      failures++;
      $display("FAIL collide_gnt got=%b exp=00",
               {sb.req1_ready, sb.req0_ready});
    end
    step();
    sb.clr_start = 0;
    while (sb.clr_busy && k < 40) begin
      if (sb.wr_en) writes++;
      if (sb.clr_done) dones++;
      sb.clr_start = (k == 5);
      step();
      k++;
    end
    sb.clr_start = 0;
    checks++;
    if (sb.clr_busy !== 1'b0) begin
      failures++;
      $display("FAIL collide_timeout got=busy exp=idle");
    end
    checks++;
    if (writes != 16 || dones != 1) begin
      failures++;
      $display("FAIL collide_count got=%0d/%0d exp=16/1", writes, dones);
    end
    checks++;
    if ({sb.wr_en, sb.wr_addr, sb.wr_data} !== {1'b1, 4'h5, 3'd6}) begin
      failures++;
      $display("FAIL collide_resume got=%b/%h/%0d exp=1/5/6",
               sb.wr_en, sb.wr_addr, sb.wr_data);
    end
    sb.req0_valid = 0; sb.req1_valid = 0;
    step();
  endtask

  task automatic test_reset_mid_clear;
    int k = 0;
    int bad = 0;
    sb.clr_start = 1; sb.clr_color = 3'd5;
    step();
    sb.clr_start = 0;
    while (!(sb.wr_en && sb.wr_addr == 4'd7) && k < 20) begin
      step();
      k++;
    end
    checks++;
    if (k >= 20) begin
      failures++;
      $display("FAIL midclr_reach got=timeout exp=addr7");
    end
    rst = 1;
    #1;
    checks++;
    if ({sb.clr_busy, sb.clr_done, sb.wr_en} !== 3'b000) begin
      failures++;
      $display("FAIL midclr_abort got=%b exp=000",
               {sb.clr_busy, sb.clr_done, sb.wr_en});
    end
    step();
    step();
    @(negedge clk);
    rst = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (sb.clr_done || sb.clr_busy || sb.wr_en) bad++;
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL midclr_quiet got=%0d exp=0", bad);
    end
    sb.req1_valid = 1; sb.req1_addr = 4'h9; sb.req1_data = 3'd6;
    #1;
    checks++;
    if ({sb.req1_ready, sb.req0_ready} !== 2'b10) begin
      failures++;
      $display("FAIL midclr_ready got=%b exp=10",
               {sb.req1_ready, sb.req0_ready});
    end
    step();
    sb.req1_valid = 0;
    checks++;
    if ({sb.wr_en, sb.wr_addr, sb.wr_data} !== {1'b1, 4'h9, 3'd6}) begin
      failures++;
      $display("FAIL midclr_serve got=%b/%h/%0d exp=1/9/6",
               sb.wr_en, sb.wr_addr, sb.wr_data);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_clear();
    test_collision();
    test_reset_mid_clear();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
